// File: rtl/jpeg_bitstream_feeder_pkg.sv
// rtl/jpeg_bitstream_feeder_pkg.sv - shared marker constants and FSM state type for the JPEG feeder
`ifndef IN_BUS_WIDTH
`define IN_BUS_WIDTH 32
`endif

package jpeg_feed_pkg;

  localparam logic [7:0] MK_PREFIX = 8'hFF;
  localparam logic [7:0] MK_STUFF  = 8'h00;
  localparam logic [7:0] MK_EOI    = 8'hD9;
  localparam logic [7:0] MK_RST0   = 8'hD0;
  localparam logic [7:0] MK_RST7   = 8'hD7;

  typedef enum logic [1:0] {NORMAL, GOT_FF, FLUSH, DONE} feed_state_t;

  // True for the restart markers RST0..RST7
  function automatic logic is_rst_marker(input logic [7:0] b);
    return (b >= MK_RST0) && (b <= MK_RST7);
  endfunction

endpackage

// File: rtl/jpeg_bitstream_feeder_if.sv
// rtl/jpeg_bitstream_feeder_if.sv - byte input and word output handshake bundle
interface jpeg_bitstream_feeder_if #(
  parameter int OUT_W = 32
) ();
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             request;
  logic [OUT_W-1:0] data_out;
  logic             valid_out;

  // Host/decoder side
  modport master (
    output byte_in, byte_valid, request,
    input  byte_ready, data_out, valid_out
  );

  // Feeder side
  modport slave (
    input  byte_in, byte_valid, request,
    output byte_ready, data_out, valid_out
  );
endinterface

// File: rtl/jpeg_bitstream_feeder_fifo.sv
// rtl/jpeg_bitstream_feeder_fifo.sv - synchronous word FIFO; the caller guarantees no overflow
module feed_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Storage write; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; simultaneous push/pop keeps count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jpeg_bitstream_feeder.sv
// rtl/jpeg_bitstream_feeder.sv - de-stuffs JPEG scan bytes, handles RSTn/EOI, packs words into a FIFO
`ifndef IN_BUS_WIDTH
`define IN_BUS_WIDTH 32
`endif

module jpeg_bitstream_feeder
  import jpeg_feed_pkg::*;
#(
  parameter int OUT_W = `IN_BUS_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  jpeg_bitstream_feeder_if.slave  bus,
  output logic                    rst_marker,
  output logic                    marker_err,
  output logic                    eoi
);

  localparam int NB = OUT_W / 8;
  localparam int BW = $clog2(NB);
  localparam int CW = $clog2(DEPTH) + 1;

  feed_state_t      state, state_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic [OUT_W-1:0] word, word_n;
  logic             to_done, to_done_n;
  logic             rm_n, me_n;
  logic             push;
  logic [OUT_W-1:0] push_data;
  logic             pack;
  logic [7:0]       pack_byte;
  logic [OUT_W-1:0] ins_word;
  logic [OUT_W-1:0] fill_word;
  logic [CW-1:0]    count;
  logic [OUT_W-1:0] head;
  logic             accept;
  logic             pop;

  // Only take bytes when any resulting word is guaranteed a FIFO slot
  assign bus.byte_ready = !rst && (state == NORMAL || state == GOT_FF) && (count < CW'(DEPTH));
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign bus.valid_out  = (count != '0);
  assign bus.data_out   = bus.valid_out ? head : '0;
  assign pop            = bus.valid_out && bus.request;
  assign eoi            = !rst && (state == DONE) && (count == '0);

  feed_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  // Next-state, marker decode and MSB-first byte packing
  always_comb begin
    state_n   = state;
    bcnt_n    = bcnt;
    word_n    = word;
    to_done_n = to_done;
    rm_n      = 1'b0;
    me_n      = 1'b0;
    push      = 1'b0;
    push_data = word;
    pack      = 1'b0;
    pack_byte = bus.byte_in;
    ins_word  = word;
    fill_word = word;

    case (state)
      NORMAL: begin
        if (accept) begin
          if (bus.byte_in == MK_PREFIX) state_n = GOT_FF;
          else                          pack    = 1'b1;
        end
      end
      GOT_FF: begin
        if (accept) begin
          if (bus.byte_in == MK_STUFF) begin
            pack      = 1'b1;
            pack_byte = MK_PREFIX;
            state_n   = NORMAL;
          end else if (bus.byte_in == MK_PREFIX) begin
            state_n = GOT_FF;
          end else if (is_rst_marker(bus.byte_in)) begin
            rm_n      = 1'b1;
            to_done_n = 1'b0;
            state_n   = FLUSH;
          end else if (bus.byte_in == MK_EOI) begin
            to_done_n = 1'b1;
            state_n   = FLUSH;
          end else begin
            me_n    = 1'b1;
            state_n = NORMAL;
          end
        end
      end
      FLUSH: begin
        // Pad unfilled low bytes with 1-bits so the decoder sees JPEG fill
        for (int i = 0; i < NB; i++) begin
          if (i >= int'(bcnt)) fill_word[OUT_W-1-8*i -: 8] = 8'hFF;
        end
        if (bcnt != '0) begin
          push      = 1'b1;
          push_data = fill_word;
        end
        bcnt_n  = '0;
        word_n  = '0;
        state_n = to_done ? DONE : NORMAL;
      end
      default: begin
        state_n = DONE;
      end
    endcase

    if (pack) begin
      ins_word[OUT_W-1-8*int'(bcnt) -: 8] = pack_byte;
      if (bcnt == BW'(NB-1)) begin
        push      = 1'b1;
        push_data = ins_word;
        bcnt_n    = '0;
        word_n    = '0;
      end else begin
        word_n = ins_word;
        bcnt_n = bcnt + BW'(1);
      end
    end
  end

  // State, packer and registered marker pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= NORMAL;
      bcnt       <= '0;
      word       <= '0;
      to_done    <= 1'b0;
      rst_marker <= 1'b0;
      marker_err <= 1'b0;
    end else begin
      state      <= state_n;
      bcnt       <= bcnt_n;
      word       <= word_n;
      to_done    <= to_done_n;
      rst_marker <= rm_n;
      marker_err <= me_n;
    end
  end

endmodule

// File: tb/tb_jpeg_bitstream_feeder.sv
// tb/tb_jpeg_bitstream_feeder.sv - directed vector bench for jpeg_bitstream_feeder
module tb_jpeg_bitstream_feeder;

  logic clk = 1'b0;
  logic rst;
  logic rst_marker, marker_err, eoi;

  always #5 clk = ~clk;

  jpeg_bitstream_feeder_if #(.OUT_W(32)) bus ();

  jpeg_bitstream_feeder #(.OUT_W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rst_marker (rst_marker),
    .marker_err (marker_err),
    .eoi        (eoi)
  );

  typedef struct {
    logic        rst;
    logic        bv;
    logic [7:0]  b;
    logic        req;
    logic        rdy;
    logic        vo;
    logic [31:0] data;
    logic        rm;
    logic        me;
    logic        eoi;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  function automatic void add(input logic r, input logic bv, input logic [7:0] b, input logic req,
                              input logic rdy, input logic vo, input logic [31:0] data,
                              input logic rm, input logic me, input logic e);
    vec_t v;
    v.rst = r; v.bv = bv; v.b = b; v.req = req;
    v.rdy = rdy; v.vo = vo; v.data = data; v.rm = rm; v.me = me; v.eoi = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: drive just after the rising edge, outputs are then read on the falling edge
  task automatic cyc(input logic r, input logic bv, input logic [7:0] b, input logic req);
    @(posedge clk);
    #1;
    rst = r; bus.byte_valid = bv; bus.byte_in = b; bus.request = req;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  vals [20];
    logic [31:0] exp_w;
    int idx, nwords, k;

    rst = 1'b1; bus.byte_valid = 1'b0; bus.byte_in = 8'h00; bus.request = 1'b1;
    repeat (2) @(posedge clk);

    //   rst bv  byte   req  rdy vo  data          rm me eoi
    add(1, 0, 8'h00, 1,  0, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'h12, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'h34, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'h56, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'h78, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 0, 8'h00, 1,  1, 1, 32'h12345678, 0, 0, 0);
    add(0, 0, 8'h00, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hFF, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'h00, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hAB, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hCD, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hEF, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 0, 8'h00, 1,  1, 1, 32'hFFABCDEF, 0, 0, 0);
    add(0, 0, 8'h00, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hFF, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hFF, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'h00, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'h01, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'h02, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'h03, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 0, 8'h00, 1,  1, 1, 32'hFF010203, 0, 0, 0);
    add(0, 1, 8'hFF, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'h42, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 0, 8'h00, 1,  1, 0, 32'h0,        0, 1, 0);
    add(0, 0, 8'h00, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hAA, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hFF, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hD3, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hBB, 1,  0, 0, 32'h0,        1, 0, 0);
    add(0, 1, 8'hBB, 1,  1, 1, 32'hAAFFFFFF, 0, 0, 0);
    add(0, 1, 8'hCC, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hDD, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hEE, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 0, 8'h00, 1,  1, 1, 32'hBBCCDDEE, 0, 0, 0);
    add(0, 1, 8'h11, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'h22, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hFF, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 1, 8'hD9, 1,  1, 0, 32'h0,        0, 0, 0);
    add(0, 0, 8'h00, 1,  0, 0, 32'h0,        0, 0, 0);
    add(0, 0, 8'h00, 1,  0, 1, 32'h1122FFFF, 0, 0, 0);
    add(0, 0, 8'h00, 1,  0, 0, 32'h0,        0, 0, 1);
    add(0, 1, 8'h33, 1,  0, 0, 32'h0,        0, 0, 1);
    add(1, 0, 8'h00, 1,  0, 0, 32'h0,        0, 0, 0);
    add(0, 0, 8'h00, 1,  1, 0, 32'h0,        0, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].bv, vecs[i].b, vecs[i].req);
      chk($sformatf("v%0d.byte_ready", i), 32'(bus.byte_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d.valid_out", i),  32'(bus.valid_out),  32'(vecs[i].vo));
      chk($sformatf("v%0d.data_out", i),   bus.data_out,        vecs[i].data);
      chk($sformatf("v%0d.rst_marker", i), 32'(rst_marker),     32'(vecs[i].rm));
      chk($sformatf("v%0d.marker_err", i), 32'(marker_err),     32'(vecs[i].me));
      chk($sformatf("v%0d.eoi", i),        32'(eoi),            32'(vecs[i].eoi));
    end

    // Backpressure: 20 bytes offered with request low, then drained
    for (int i = 0; i < 20; i++) vals[i] = 8'(i + 1);
    idx = 0;
    for (int c = 0; c < 24; c++) begin
      cyc(1'b0, idx < 20, (idx < 20) ? vals[idx] : 8'h00, 1'b0);
      if (bus.byte_valid && bus.byte_ready) idx++;
    end
    chk("bp.accepted", 32'(idx), 32'd16);
    chk("bp.byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("bp.valid_out", 32'(bus.valid_out), 32'd1);
    chk("bp.head", bus.data_out, 32'h01020304);
    nwords = 0;
    for (int c = 0; c < 40 && !(nwords == 5 && idx == 20); c++) begin
      cyc(1'b0, idx < 20, (idx < 20) ? vals[idx] : 8'h00, 1'b1);
      if (bus.valid_out && bus.request) begin
        k = 4 * nwords;
        exp_w = {8'(k + 1), 8'(k + 2), 8'(k + 3), 8'(k + 4)};
        chk($sformatf("bp.word%0d", nwords), bus.data_out, exp_w);
        nwords++;
      end
      if (bus.byte_valid && bus.byte_ready) idx++;
    end
    chk("bp.word_total", 32'(nwords), 32'd5);
    chk("bp.byte_total", 32'(idx), 32'd20);

    // Reset in the middle of a partial word discards it
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'hAB, 1'b1);
    cyc(1'b0, 1'b1, 8'hCD, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("mid.ready_in_rst", 32'(bus.byte_ready), 32'd0);
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    chk("mid.ready_after", 32'(bus.byte_ready), 32'd1);
    chk("mid.valid_after", 32'(bus.valid_out), 32'd0);
    chk("mid.data_after", bus.data_out, 32'h0);
    cyc(1'b0, 1'b1, 8'h02, 1'b1);
    cyc(1'b0, 1'b1, 8'h03, 1'b1);
    cyc(1'b0, 1'b1, 8'h04, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("mid.fresh_valid", 32'(bus.valid_out), 32'd1);
    chk("mid.fresh_word", bus.data_out, 32'h01020304);

    // Reset with a queued word empties the FIFO
    cyc(1'b0, 1'b1, 8'h55, 1'b0);
    cyc(1'b0, 1'b1, 8'h66, 1'b0);
    cyc(1'b0, 1'b1, 8'h77, 1'b0);
    cyc(1'b0, 1'b1, 8'h88, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("fq.valid_before", 32'(bus.valid_out), 32'd1);
    chk("fq.word_before", bus.data_out, 32'h55667788);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("fq.valid_after", 32'(bus.valid_out), 32'd0);
    chk("fq.data_after", bus.data_out, 32'h0);
    chk("fq.pulses", 32'({rst_marker, marker_err, eoi}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
